// File: rtl/pc_sel_gen.sv
// pc_sel_gen: IF-stage owner of the fetch PC and producer of the next-PC mux select.
// Arbitrates EX and ID redirects and parks a redirect that arrives during a fetch stall.
//
// state | meaning
// BOOT  | first cycle out of reset; pc = RESET_PC, requests ignored
// RUN   | normal fetch; redirects applied on the next edge
// HOLD  | stalled with a redirect parked in pend_*; applied when the stall drops

// Shared 3-input next-PC mux: index 0 = PC_4, 1 = PC_ALU, 2 = PC_TGT.
module mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  // Select one of three sources; unused code 3 falls back to the sequential PC.
  always_comb begin
    out = in0;
    case (sel)
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in0;
    endcase
  end

endmodule

module pc_sel_gen #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_redirect,
  input  logic [WIDTH-1:0] ex_alu,
  input  logic             id_jump,
  input  logic [WIDTH-1:0] id_target,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [1:0]       pc_sel,
  output logic             flush_ifid
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  typedef enum logic [1:0] {PC_4 = 2'd0, PC_ALU = 2'd1, PC_TGT = 2'd2} sel_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             pc_valid_nxt;
  logic             pend_vld, pend_vld_nxt;
  sel_t             pend_sel, pend_sel_nxt;
  logic [WIDTH-1:0] pend_target, pend_target_nxt;

  logic [WIDTH-1:0] ex_tgt, id_tgt, pc_plus4, mux_out;
  sel_t             arb_sel;

  // Targets are halfword-aligned at minimum; bit 0 is never a valid fetch bit.
  assign ex_tgt   = {ex_alu[WIDTH-1:1], 1'b0};
  assign id_tgt   = {id_target[WIDTH-1:1], 1'b0};
  assign pc_plus4 = pc + WIDTH'(4);

  // EX is the older instruction, so it beats a same-cycle ID jump.
  assign arb_sel = ex_redirect ? PC_ALU : (id_jump ? PC_TGT : PC_4);

  mux #(.WIDTH(WIDTH)) u_mux (
    .in0 (pc_plus4),
    .in1 (ex_tgt),
    .in2 (id_tgt),
    .sel (arb_sel),
    .out (mux_out)
  );

  // Next-state, next-PC, pending-redirect and select/flush decode.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pc_valid_nxt    = pc_valid;
    pend_vld_nxt    = pend_vld;
    pend_sel_nxt    = pend_sel;
    pend_target_nxt = pend_target;
    pc_sel          = PC_4;
    flush_ifid      = 1'b0;

    case (state)
      BOOT: begin
        pc_valid_nxt = 1'b1;
        state_nxt    = RUN;
      end
      RUN: begin
        if (!stall) begin
          pc_sel     = arb_sel;
          flush_ifid = ex_redirect | id_jump;
          pc_nxt     = mux_out;
        end else if (ex_redirect || id_jump) begin
          flush_ifid      = 1'b1;
          pend_vld_nxt    = 1'b1;
          pend_sel_nxt    = arb_sel;
          pend_target_nxt = ex_redirect ? ex_tgt : id_tgt;
          state_nxt       = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (ex_redirect) begin
            flush_ifid      = 1'b1;
            pend_sel_nxt    = PC_ALU;
            pend_target_nxt = ex_tgt;
          end else if (id_jump && pend_sel != PC_ALU) begin
            flush_ifid      = 1'b1;
            pend_sel_nxt    = PC_TGT;
            pend_target_nxt = id_tgt;
          end
        end else begin
          // A fresh EX redirect is older than anything parked; ID never overrides.
          if (ex_redirect) begin
            pc_sel     = PC_ALU;
            flush_ifid = 1'b1;
            pc_nxt     = ex_tgt;
          end else begin
            pc_sel = pend_sel;
            pc_nxt = pend_target;
          end
          pend_vld_nxt = 1'b0;
          state_nxt    = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase

    if (rst) begin
      pc_sel     = PC_4;
      flush_ifid = 1'b0;
    end
  end

  // State and fetch PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      pend_vld    <= 1'b0;
      pend_sel    <= PC_4;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pc_valid    <= pc_valid_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_sel    <= pend_sel_nxt;
      pend_target <= pend_target_nxt;
    end
  end

endmodule
